// File: rtl/fetch_queue_pkg.sv
// fetch_queue_pkg: shared IF/ID entry defaults and queue control types.
package fetch_queue_pkg;
    localparam int DEF_INSTR_W = 32;
    localparam int DEF_PC_W = 32;
    localparam int DEF_DEPTH = 4;
    localparam logic [31:0] DEF_NOP_INSTR = 32'h0100_0000;
    typedef enum logic [1:0] {FL_NONE, FL_ALL, FL_KEEP} flush_e;
endpackage

// File: rtl/fetch_queue_mem.sv
// fetch_queue_mem: entry storage with synchronous write and asynchronous read, no reset.
module fetch_queue_mem #(
    parameter int W = 64,
    parameter int DEPTH = 4,
    parameter int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);
    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: show-ahead IF/ID instruction queue with stall, flush and delay-slot flush.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int INSTR_W = DEF_INSTR_W,
    parameter int PC_W = DEF_PC_W,
    parameter int DEPTH = DEF_DEPTH,
    parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(DEF_NOP_INSTR),
    parameter int AW = $clog2(DEPTH),
    parameter int CW = $clog2(DEPTH + 1)
) (
    input  logic               Clk,
    input  logic               R,
    input  logic               push_valid,
    output logic               push_ready,
    input  logic [INSTR_W-1:0] push_instr,
    input  logic [PC_W-1:0]    push_pc,
    input  logic               pop_en,
    output logic               pop_valid,
    output logic [INSTR_W-1:0] pop_instr,
    output logic [PC_W-1:0]    pop_pc,
    input  logic               flush,
    input  logic               flush_keep,
    output logic [CW-1:0]      count
);
    logic [AW-1:0] rd_ptr, wr_ptr, rd_nxt;
    logic [INSTR_W+PC_W-1:0] head;
    logic empty, do_push, do_pop;
    flush_e mode;

    assign empty = count == '0;
    assign push_ready = count != CW'(DEPTH);
    assign pop_valid = !empty;
    assign do_pop = pop_en && !empty;
    // flush wins over push, so a flushed cycle never writes storage
    assign do_push = push_valid && push_ready && !flush;
    assign rd_nxt = rd_ptr + AW'(do_pop);

    always_comb begin
        mode = FL_NONE;
        if (flush) mode = (flush_keep && !do_pop && !empty) ? FL_KEEP : FL_ALL;
    end

    always_ff @(posedge Clk or negedge R) begin
        if (!R) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count <= '0;
        end else begin
            rd_ptr <= rd_nxt;
            if (mode == FL_KEEP) begin
                wr_ptr <= rd_ptr + AW'(1);
                count <= CW'(1);
            end else if (mode == FL_ALL) begin
                wr_ptr <= rd_nxt;
                count <= '0;
            end else begin
                wr_ptr <= wr_ptr + AW'(do_push);
                count <= count + CW'(do_push) - CW'(do_pop);
            end
        end
    end

    fetch_queue_mem #(.W(INSTR_W + PC_W), .DEPTH(DEPTH)) u_mem (
        .clk   (Clk),
        .we    (do_push),
        .waddr (wr_ptr),
        .wdata ({push_instr, push_pc}),
        .raddr (rd_ptr),
        .rdata (head)
    );

    assign pop_instr = empty ? NOP_INSTR : head[PC_W +: INSTR_W];
    assign pop_pc = empty ? '0 : head[PC_W-1:0];
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed and random checks of fetch_queue against a queue-based model.
module tb_fetch_queue;
    localparam int DEPTH = 4;
    localparam logic [31:0] NOP = 32'h0100_0000;

    logic Clk = 0, R = 0;
    logic push_valid = 0, push_ready, pop_en = 0, pop_valid, flush = 0, flush_keep = 0;
    logic [31:0] push_instr = 0, push_pc = 0, pop_instr, pop_pc;
    logic [2:0] count;

    int total = 0, bad = 0;
    logic [63:0] q[$];
    logic [31:0] exp_pc;

    fetch_queue dut (
        .Clk(Clk), .R(R), .push_valid(push_valid), .push_ready(push_ready),
        .push_instr(push_instr), .push_pc(push_pc), .pop_en(pop_en),
        .pop_valid(pop_valid), .pop_instr(pop_instr), .pop_pc(pop_pc),
        .flush(flush), .flush_keep(flush_keep), .count(count)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".count"}, 64'(count), 64'(q.size()));
        chk({tag, ".pop_valid"}, 64'(pop_valid), 64'(q.size() > 0));
        chk({tag, ".push_ready"}, 64'(push_ready), 64'(q.size() < DEPTH));
        chk({tag, ".pop_instr"}, 64'(pop_instr), 64'(q.size() > 0 ? q[0][63:32] : NOP));
        chk({tag, ".pop_pc"}, 64'(pop_pc), 64'(q.size() > 0 ? q[0][31:0] : 32'h0));
    endtask

    // One clock: apply inputs, advance the model by the queue rules, check at the falling edge.
    task automatic cyc(input string tag, input logic pv, input logic [31:0] pi, input logic [31:0] ppc,
                       input logic pe, input logic fl, input logic fk);
        int n;
        bit pushf, popf;
        logic [63:0] e;
        push_valid = pv; push_instr = pi; push_pc = ppc;
        pop_en = pe; flush = fl; flush_keep = fk;
        n = q.size();
        pushf = pv && n < DEPTH;
        popf = pe && n > 0;
        if (fl) begin
            if (fk && !popf && n > 0) begin
                e = q[0];
                q.delete();
                q.push_back(e);
            end else q.delete();
        end else begin
            if (popf) void'(q.pop_front());
            if (pushf) q.push_back({pi, ppc});
        end
        @(posedge Clk);
        @(negedge Clk);
        push_valid = 0; pop_en = 0; flush = 0; flush_keep = 0;
        check_all(tag);
    endtask

    task automatic push3(input string tag);
        cyc(tag, 1, $urandom, 16, 0, 0, 0);
        cyc(tag, 1, $urandom, 20, 0, 0, 0);
        cyc(tag, 1, $urandom, 24, 0, 0, 0);
        chk({tag, ".cnt3"}, 64'(count), 64'd3);
    endtask

    initial begin
        #3 R = 1;
        #1;
        chk("t1.count", 64'(count), 64'd0);
        chk("t1.pop_valid", 64'(pop_valid), 64'd0);
        chk("t1.pop_instr", 64'(pop_instr), 64'(NOP));
        chk("t1.pop_pc", 64'(pop_pc), 64'd0);
        chk("t1.push_ready", 64'(push_ready), 64'd1);
        @(negedge Clk);

        for (int i = 0; i < 5; i++) cyc("t2.fill", 1, $urandom, 32'(4 * i), 0, 0, 0);
        chk("t2.full_count", 64'(count), 64'd4);
        chk("t2.full_ready", 64'(push_ready), 64'd0);
        for (int i = 0; i < 4; i++) begin
            chk("t2.order", 64'(pop_pc), 64'(4 * i));
            cyc("t2.drain", 0, 0, 0, 1, 0, 0);
        end
        chk("t2.empty_instr", 64'(pop_instr), 64'(NOP));
        chk("t2.empty_valid", 64'(pop_valid), 64'd0);
        cyc("t2.pop_empty", 0, 0, 0, 1, 0, 0);

        cyc("t3.pre", 1, $urandom, 100, 0, 0, 0);
        cyc("t3.pre", 1, $urandom, 104, 0, 0, 0);
        exp_pc = 100;
        for (int i = 0; i < 10; i++) begin
            chk("t3.seq", 64'(pop_pc), 64'(exp_pc));
            cyc("t3.pp", 1, $urandom, 32'(108 + 4 * i), 1, 0, 0);
            chk("t3.count", 64'(count), 64'd2);
            exp_pc += 4;
        end
        cyc("t3.clear", 0, 0, 0, 0, 1, 0);

        push3("t4");
        cyc("t4.flush", 1, $urandom, 28, 0, 1, 0);
        chk("t4.count", 64'(count), 64'd0);
        chk("t4.nop", 64'(pop_instr), 64'(NOP));
        cyc("t4.after", 0, 0, 0, 0, 0, 0);

        push3("t5");
        cyc("t5.keep", 1, $urandom, 28, 0, 1, 1);
        chk("t5.count", 64'(count), 64'd1);
        chk("t5.pc", 64'(pop_pc), 64'd16);
        cyc("t5.clear", 0, 0, 0, 1, 0, 0);

        push3("t6");
        chk("t6.head", 64'(pop_pc), 64'd16);
        cyc("t6.keep_pop", 0, 0, 0, 1, 1, 1);
        chk("t6.count", 64'(count), 64'd0);

        push3("t7");
        #2 R = 0;
        #1;
        q.delete();
        chk("t7.count", 64'(count), 64'd0);
        chk("t7.pop_valid", 64'(pop_valid), 64'd0);
        #1 R = 1;
        @(negedge Clk);
        check_all("t7.after");

        for (int i = 0; i < 400; i++) begin
            logic fl;
            fl = $urandom_range(0, 15) == 0;
            cyc("rnd", 1'($urandom_range(0, 3) != 0), $urandom, $urandom, 1'($urandom_range(0, 2) == 0),
                fl, 1'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
